// File: rtl/card_display_mux.sv
// card_display_mux: time-multiplexed seven-segment driver for the card table.
// Each card uses two digits: rank glyph on digit 2k and suit glyph on digit 2k+1.
// Card data is double-buffered. The display reads only the shadow registers,
// which load_in fills. Each card has its own valid (blanking) bit and blink bit.
// cat_out and an_out are registered and have one cycle of latency.
module card_display_mux #(
    parameter int NUM_CARDS    = 4,
    parameter int COUNT_PERIOD = 100000,
    parameter int BLINK_PERIOD = 25000000
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [6*NUM_CARDS-1:0]   cards_in,
    input  logic [NUM_CARDS-1:0]     valid_in,
    input  logic [NUM_CARDS-1:0]     blink_in,
    input  logic                     load_in,
    output logic [6:0]               cat_out,
    output logic [2*NUM_CARDS-1:0]   an_out
);

    localparam int NUM_DIGITS = 2 * NUM_CARDS;
    localparam int IDX_W      = $clog2(NUM_DIGITS);
    localparam int REF_W      = $clog2(COUNT_PERIOD);
    localparam int BLK_W      = $clog2(BLINK_PERIOD);

    localparam logic [REF_W-1:0] REF_LAST = REF_W'(COUNT_PERIOD - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_PERIOD - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [6*NUM_CARDS-1:0] shadow_cards;
    logic [NUM_CARDS-1:0]   shadow_valid;
    logic [NUM_CARDS-1:0]   shadow_blink;
    logic [REF_W-1:0]       refresh_cnt;
    logic [IDX_W-1:0]       digit_idx;
    logic [BLK_W-1:0]       blink_cnt;
    logic                   blink_phase;
    logic [6:0]             cat_next;
    logic [NUM_DIGITS-1:0]  an_next;

    // Rank glyph, active-high {g..a}. Ranks 0, 14 and 15 show a dash.
    function automatic logic [6:0] rank_glyph(input logic [3:0] rank);
        case (rank)
            4'd1:    rank_glyph = 7'b1110111;
            4'd2:    rank_glyph = 7'b1011011;
            4'd3:    rank_glyph = 7'b1001111;
            4'd4:    rank_glyph = 7'b1100110;
            4'd5:    rank_glyph = 7'b1101101;
            4'd6:    rank_glyph = 7'b1111101;
            4'd7:    rank_glyph = 7'b0000111;
            4'd8:    rank_glyph = 7'b1111111;
            4'd9:    rank_glyph = 7'b1101111;
            4'd10:   rank_glyph = 7'b1111000;
            4'd11:   rank_glyph = 7'b0011110;
            4'd12:   rank_glyph = 7'b1100111;
            4'd13:   rank_glyph = 7'b1110110;
            default: rank_glyph = 7'b1000000;
        endcase
    endfunction

    // Suit glyph, active-high {g..a}: diamond, heart, club, spade.
    function automatic logic [6:0] suit_glyph(input logic [1:0] suit);
        case (suit)
            2'b00:   suit_glyph = 7'b1011110;
            2'b01:   suit_glyph = 7'b1110100;
            2'b10:   suit_glyph = 7'b0111001;
            default: suit_glyph = 7'b1101101;
        endcase
    endfunction

    // Shadow registers: capture the live card inputs on a load strobe.
    always_ff @(posedge clk_in) begin
        // NOTE: non-blocking assignments for all state, so every register samples pre-edge values.
        if (rst_in) begin
            shadow_cards <= '0;
            shadow_valid <= '0;
            shadow_blink <= '0;
        end else if (load_in) begin
            shadow_cards <= cards_in;
            shadow_valid <= valid_in;
            shadow_blink <= blink_in;
        end
    end

    // Scan: hold each digit for COUNT_PERIOD cycles, then advance and wrap.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
        end else if (refresh_cnt == REF_LAST) begin
            refresh_cnt <= '0;
            digit_idx   <= (digit_idx == IDX_LAST) ? '0 : digit_idx + IDX_W'(1);
        end else begin
            refresh_cnt <= refresh_cnt + REF_W'(1);
        end
    end

    // Blink timebase: toggle the phase every BLINK_PERIOD cycles, independent of the scan.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + BLK_W'(1);
        end
    end

    // Cathode/anode decode for the current digit. Priority: invalid > blink-off > glyph.
    always_comb begin
        // NOTE: defaults come first so every path assigns both outputs, which avoids inferred latches.
        cat_next = 7'h7F;
        an_next  = ~(NUM_DIGITS'(1) << digit_idx);
        for (int k = 0; k < NUM_CARDS; k++) begin
            if (digit_idx == IDX_W'(2 * k) || digit_idx == IDX_W'(2 * k + 1)) begin
                if (!shadow_valid[k]) begin
                    cat_next = 7'h7F;
                end else if (blink_phase && shadow_blink[k]) begin
                    cat_next = 7'h7F;
                end else if (digit_idx[0]) begin
                    cat_next = ~suit_glyph(shadow_cards[6 * k +: 2]);
                end else begin
                    cat_next = ~rank_glyph(shadow_cards[6 * k + 2 +: 4]);
                end
            end
        end
    end

    // Output registers: one cycle of latency from the digit index and shadow state.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cat_out <= 7'h7F;
            an_out  <= '1;
        end else begin
            cat_out <= cat_next;
            an_out  <= an_next;
        end
    end

endmodule

// File: doc/card_display_mux.md
Name: card_display_mux

Overview:
- Time-multiplexed seven-segment driver for the card table display.
- Shows up to NUM_CARDS cards, each on two digits: a rank glyph and a suit glyph.
- Adds what the single-digit combinational suit decoder lacked: multi-digit scanning, double-buffered card load, per-card valid blanking and per-card blink.
- Sits between game logic and the board's shared-cathode display pins.

Parameters:
- NUM_CARDS, 4, number of cards shown; digits = 2*NUM_CARDS, legal range 1..4.
- COUNT_PERIOD, 100000, clk_in cycles each digit is held; must be >= 2.
- BLINK_PERIOD, 25000000, clk_in cycles per blink half-phase; must be >= 2.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous, active-high reset.
- cards_in  input  6*NUM_CARDS  card k occupies bits [6k+5:6k]: rank [6k+5:6k+2], suit [6k+1:6k] (00 diamond, 01 heart, 10 club, 11 spade).
- valid_in  input  NUM_CARDS  bit k high = card k present.
- blink_in  input  NUM_CARDS  bit k high = card k blinks.
- load_in  input  1  single-cycle strobe; captures cards_in, valid_in and blink_in.
- cat_out  output  7  active-low segments {g,f,e,d,c,b,a}.
- an_out  output  2*NUM_CARDS  active-low digit enables, one-hot-low.

Behaviour:
- Clock and reset: one clock, clk_in; rst_in is synchronous and active-high.
- Reset values:
  - shadow cards, valid and blink registers: 0.
  - refresh counter, digit index, blink counter, blink phase: 0.
  - cat_out: 7'h7F; an_out: all ones.
  - rst_in mid-scan or mid-blink aborts immediately to these values.
- Load:
  - load_in high at edge t updates the shadow registers at t+1.
  - The display uses only shadow registers, never the live inputs.
  - load_in held high reloads every cycle.
  - load_in coincident with rst_in: reset wins.
- Scan:
  - The refresh counter counts 0..COUNT_PERIOD-1.
  - At terminal count it wraps to 0 and the digit index increments.
  - The digit index wraps from 2*NUM_CARDS-1 to 0.
- Digit mapping: digit 2k shows the rank of card k; digit 2k+1 shows the suit of card k.
- Output timing:
  - cat_out and an_out are registered and reflect the digit index and shadow state of the previous cycle (1-cycle latency).
  - an_out[i] is low exactly when the registered index equals i; all other bits are high.
  - There is no all-high gap between digits except during reset.
- Suit glyphs (active-high, {g..a}), cat_out = bitwise inverse:
  - diamond 7'b1011110
  - heart 7'b1110100
  - club 7'b0111001
  - spade 7'b1101101
- Rank glyphs (active-high):
  - 1 (A) 7'b1110111, 2 7'b1011011, 3 7'b1001111, 4 7'b1100110, 5 7'b1101101
  - 6 7'b1111101, 7 7'b0000111, 8 7'b1111111, 9 7'b1101111
  - 10 (t) 7'b1111000, 11 (J) 7'b0011110, 12 (q) 7'b1100111, 13 (K) 7'b1110110
  - 0, 14, 15 show a dash, 7'b1000000.
- Blanking:
  - Shadow valid bit k low: both digits of card k show cat_out 7'h7F; the anode still scans.
- Blink:
  - The blink counter counts 0..BLINK_PERIOD-1 and toggles the phase at terminal count.
  - While phase is 1 and shadow blink bit k is 1, card k's digits show 7'h7F.
  - Phase 0 displays normally.
  - Blink and scan counters run independently and never reset each other.
- Priority for a digit's cathode: reset > invalid > blink-off > glyph.

Test Plan:
- Reset then scan, COUNT_PERIOD=4, NUM_CARDS=2 -> an_out steps 1110, 1101, 1011, 0111, 1110, each held exactly 4 cycles; first active pattern appears 1 cycle after rst_in falls.
- Load card0 = rank 1, suit 01 and card1 = rank 13, suit 11, both valid -> cat_out reads ~A, ~heart, ~K, ~spade: 7'h08, 7'h0B, 7'h09, 7'h12.
- Change cards_in without load_in -> cat_out unchanged; pulse load_in -> new glyph visible on the next cycle the affected digit is driven (2 cycles after the strobe if already selected).
- valid_in = 2'b01 loaded -> digits 2 and 3 show 7'h7F while an_out still cycles all four digits; rank 14 on card0 -> digit 0 shows 7'h3F.
- BLINK_PERIOD=32, blink_in = 2'b10 -> card1 digits alternate glyph / 7'h7F every 32 cycles; card0 is never blanked.
- Assert rst_in mid-digit and mid-blink -> next cycle cat_out = 7'h7F, an_out all ones, shadows cleared; scan restarts at digit 0 with blink phase 0.
